// File: rtl/mac_acc_if.sv
// Operand/result handshake bundle for mac_acc.
// The master drives operand beats, flush strobes and result acceptance; the slave is the accumulator.
interface mac_acc_if #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_ACC = 20,
    parameter int WIDTH_CNT = 16
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic signed [WIDTH_IN-1:0]  a_i;
    logic signed [WIDTH_IN-1:0]  b_i;
    logic                        flush_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic signed [WIDTH_ACC-1:0] out_data_o;
    logic [WIDTH_CNT-1:0]        out_cnt_o;
    logic                        out_ovf_o;

    modport master (
        output in_valid_i, a_i, b_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_ovf_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_cnt_o, out_ovf_o
    );
endinterface

// File: rtl/mac_acc.sv
// Windowed signed multiply-accumulate with saturation, beat count and sticky overflow.
// A flush strobe closes the window; the result is held until downstream accepts it.
module mac_acc #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_ACC = 20,
    parameter int WIDTH_CNT = 16
) (
    input logic     clk,
    input logic     rst,
    mac_acc_if.slave bus
);
    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WIDTH_PROD = 2 * WIDTH_IN;
    localparam logic signed [WIDTH_ACC-1:0] ACC_MAX = {1'b0, {(WIDTH_ACC-1){1'b1}}};
    localparam logic signed [WIDTH_ACC-1:0] ACC_MIN = {1'b1, {(WIDTH_ACC-1){1'b0}}};

    state_t                       state_q;
    state_t                       state_d;
    logic                         pending_q;
    logic                         pending_d;
    logic                         in_ready_q;
    logic                         out_valid_q;
    logic                         accept;
    logic                         out_fire;

    logic signed [WIDTH_PROD-1:0] prod_q;
    logic                         prod_vld_q;
    logic signed [WIDTH_ACC-1:0]  acc_q;
    logic signed [WIDTH_ACC:0]    acc_sum;
    logic signed [WIDTH_ACC-1:0]  acc_sat;
    logic                         sat_hit;
    logic [WIDTH_CNT-1:0]         cnt_q;
    logic                         ovf_q;

    // State register; the handshake flags are registered from the next state
    // so that both read 0 throughout reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            pending_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            in_ready_q  <= (state_d == ACC);
            out_valid_q <= (state_d == DRAIN);
        end
    end

    // Next-state logic. A strobe arriving on the handshake cycle itself is
    // treated like one already pending: the next (empty) window closes at once.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            ACC: begin
                if (bus.flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                state_d = DRAIN;
                if (bus.flush_i) pending_d = 1'b1;
            end
            DRAIN: begin
                if (out_fire) begin
                    state_d   = (pending_q || bus.flush_i) ? FLUSH : ACC;
                    pending_d = 1'b0;
                end else if (bus.flush_i) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d   = ACC;
                pending_d = 1'b0;
            end
        endcase
    end

    // Output / handshake decode.
    always_comb begin
        accept   = bus.in_valid_i && in_ready_q;
        out_fire = out_valid_q && bus.out_ready_i;
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = acc_q;
    assign bus.out_cnt_o   = cnt_q;
    assign bus.out_ovf_o   = ovf_q;

    // One guard bit above the accumulator detects overflow in either direction.
    always_comb begin
        acc_sum = {acc_q[WIDTH_ACC-1], acc_q}
                + {{(WIDTH_ACC+1-WIDTH_PROD){prod_q[WIDTH_PROD-1]}}, prod_q};
        sat_hit = (acc_sum[WIDTH_ACC] != acc_sum[WIDTH_ACC-1]);
        if (!sat_hit) begin
            acc_sat = acc_sum[WIDTH_ACC-1:0];
        end else if (acc_sum[WIDTH_ACC]) begin
            acc_sat = ACC_MIN;
        end else begin
            acc_sat = ACC_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            prod_vld_q <= accept;
            if (accept) begin
                prod_q <= WIDTH_PROD'(bus.a_i) * WIDTH_PROD'(bus.b_i);
            end

            if (out_fire) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (prod_vld_q) begin
                    acc_q <= acc_sat;
                    if (sat_hit) ovf_q <= 1'b1;
                end
                if (accept && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + WIDTH_CNT'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_mac_acc.sv
// Self-checking bench for mac_acc: vector table of windows plus hand-written
// sequences for latency, backpressure, pending flush and mid-result reset.
module tb_mac_acc;
    localparam int WI = 8;
    localparam int WA = 20;
    localparam int WC = 16;
    localparam longint ACC_MAX = 524287;
    localparam longint ACC_MIN = -524288;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_acc_if #(.WIDTH_IN(WI), .WIDTH_ACC(WA), .WIDTH_CNT(WC)) bus ();

    mac_acc #(.WIDTH_IN(WI), .WIDTH_ACC(WA), .WIDTH_CNT(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        longint data;
        longint cnt;
        longint ovf;
    } res_t;

    typedef struct {
        int     n;
        int     a;
        int     b;
        longint exp_data;
        longint exp_cnt;
        longint exp_ovf;
    } vec_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !bus.in_ready_o; i++) @(negedge clk);
        check({name, "_in_ready"}, longint'(bus.in_ready_o), 1);
    endtask

    // Drives n identical beats, flush on the last one (or a bare flush when n==0).
    task automatic drive_window(input string name, input int n, input int a, input int b,
                                input res_t exp, input bit push);
        wait_ready(name);
        if (n == 0) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
        end
        for (int i = 0; i < n; i++) begin
            bus.in_valid_i = 1'b1;
            bus.a_i        = WI'(a);
            bus.b_i        = WI'(b);
            bus.flush_i    = (i == n - 1);
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        if (push) sb.push_back(exp);
    endtask

    task automatic collect(input string name, input int hold);
        res_t e;
        int   t = 0;
        while (!bus.out_valid_o && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid_o) begin
            check({name, "_out_valid_timeout"}, longint'(bus.out_valid_o), 1);
            return;
        end
        if (sb.size() == 0) begin
            check({name, "_unexpected_result"}, longint'(sb.size()), 1);
            bus.out_ready_i = 1'b1;
            @(negedge clk);
            bus.out_ready_i = 1'b0;
            return;
        end
        e = sb.pop_front();
        check({name, "_data"}, longint'(bus.out_data_o), e.data);
        check({name, "_cnt"},  longint'(bus.out_cnt_o),  e.cnt);
        check({name, "_ovf"},  longint'(bus.out_ovf_o),  e.ovf);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready_i = 1'b0;
            @(negedge clk);
            check({name, "_hold_valid"}, longint'(bus.out_valid_o), 1);
            check({name, "_hold_ready"}, longint'(bus.in_ready_o), 0);
            check({name, "_hold_data"},  longint'(bus.out_data_o), e.data);
            check({name, "_hold_cnt"},   longint'(bus.out_cnt_o),  e.cnt);
            check({name, "_hold_ovf"},   longint'(bus.out_ovf_o),  e.ovf);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs[6];
        res_t   r;
        int     ba[3];
        int     bb[3];
        longint m_sum;
        longint m_ovf;
        bit     seen;

        vecs[0] = '{n: 1,  a: 3,    b: 4,    exp_data: 12,      exp_cnt: 1,  exp_ovf: 0};
        vecs[1] = '{n: 4,  a: -2,   b: 5,    exp_data: -40,     exp_cnt: 4,  exp_ovf: 0};
        vecs[2] = '{n: 33, a: 127,  b: 127,  exp_data: ACC_MAX, exp_cnt: 33, exp_ovf: 1};
        vecs[3] = '{n: 33, a: -128, b: 127,  exp_data: ACC_MIN, exp_cnt: 33, exp_ovf: 1};
        vecs[4] = '{n: 31, a: -128, b: -128, exp_data: 507904,  exp_cnt: 31, exp_ovf: 0};
        vecs[5] = '{n: 32, a: -128, b: -128, exp_data: ACC_MAX, exp_cnt: 32, exp_ovf: 1};

        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;

        // Reset held for three rising edges
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid_o), 0);
        check("rst_in_ready",  longint'(bus.in_ready_o),  0);
        check("rst_data",      longint'(bus.out_data_o),  0);
        check("rst_cnt",       longint'(bus.out_cnt_o),   0);
        check("rst_ovf",       longint'(bus.out_ovf_o),   0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(bus.in_ready_o), 1);

        // Basic window with flush-to-valid latency
        ba = '{3, -2, 7};
        bb = '{4, 5, 7};
        wait_ready("basic");
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_i = 1'b1;
            bus.a_i        = WI'(ba[i]);
            bus.b_i        = WI'(bb[i]);
            bus.flush_i    = (i == 2);
            @(negedge clk);
        end
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b0;
        check("basic_lat_f1_valid", longint'(bus.out_valid_o), 0);
        check("basic_lat_f1_ready", longint'(bus.in_ready_o),  0);
        @(negedge clk);
        check("basic_lat_f2_valid", longint'(bus.out_valid_o), 1);
        sb.push_back('{data: 51, cnt: 3, ovf: 0});
        collect("basic", 0);

        // Vector table
        foreach (vecs[i]) begin
            r = '{data: vecs[i].exp_data, cnt: vecs[i].exp_cnt, ovf: vecs[i].exp_ovf};
            drive_window($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b, r, 1'b1);
            collect($sformatf("vec%0d", i), 0);
        end

        // Backpressure, then an immediate empty window
        drive_window("bp", 2, 5, 5, '{data: 50, cnt: 2, ovf: 0}, 1'b1);
        collect("bp", 5);
        drive_window("bp_empty", 0, 0, 0, '{data: 0, cnt: 0, ovf: 0}, 1'b1);
        collect("bp_empty", 0);

        // Random short windows against a saturating model
        for (int w = 0; w < 4; w++) begin
            int n = int'($urandom_range(1, 6));
            m_sum = 0;
            m_ovf = 0;
            wait_ready("rnd");
            for (int i = 0; i < n; i++) begin
                int a = int'($urandom_range(0, 255)) - 128;
                int b = int'($urandom_range(0, 255)) - 128;
                m_sum = m_sum + longint'(a) * longint'(b);
                if (m_sum > ACC_MAX) begin m_sum = ACC_MAX; m_ovf = 1; end
                if (m_sum < ACC_MIN) begin m_sum = ACC_MIN; m_ovf = 1; end
                bus.in_valid_i = 1'b1;
                bus.a_i        = WI'(a);
                bus.b_i        = WI'(b);
                bus.flush_i    = (i == n - 1);
                @(negedge clk);
            end
            bus.in_valid_i = 1'b0;
            bus.flush_i    = 1'b0;
            sb.push_back('{data: m_sum, cnt: longint'(n), ovf: m_ovf});
            collect($sformatf("rnd%0d", w), 1);
        end

        // Pending flush: strobe in FLUSH, then twice in DRAIN
        wait_ready("pend");
        bus.in_valid_i = 1'b1;
        bus.a_i        = WI'(6);
        bus.b_i        = WI'(-3);
        bus.flush_i    = 1'b1;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        bus.flush_i    = 1'b1;
        @(negedge clk);
        check("pend_drain_valid", longint'(bus.out_valid_o), 1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        sb.push_back('{data: -18, cnt: 1, ovf: 0});
        sb.push_back('{data: 0, cnt: 0, ovf: 0});
        collect("pend_first", 0);
        collect("pend_second", 0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= bus.out_valid_o;
            @(negedge clk);
        end
        check("pend_no_third", longint'(seen), 0);
        check("pend_back_to_acc", longint'(bus.in_ready_o), 1);

        // Reset while a result is being presented
        drive_window("rst_mid", 5, 2, 3, '{data: 30, cnt: 5, ovf: 0}, 1'b0);
        for (int i = 0; i < 20 && !bus.out_valid_o; i++) @(negedge clk);
        check("rst_mid_drain_valid", longint'(bus.out_valid_o), 1);
        check("rst_mid_drain_data",  longint'(bus.out_data_o),  30);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", longint'(bus.out_valid_o), 0);
        check("rst_mid_data",  longint'(bus.out_data_o),  0);
        check("rst_mid_cnt",   longint'(bus.out_cnt_o),   0);
        check("rst_mid_ready", longint'(bus.in_ready_o),  0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_release_ready", longint'(bus.in_ready_o), 1);
        drive_window("rst_mid_empty", 0, 0, 0, '{data: 0, cnt: 0, ovf: 0}, 1'b1);
        collect("rst_mid_empty", 0);

        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
